data_memory: RTL and testbench
==============================

# data_memory

Parametrised byte-addressable data memory for the core's load/store path, succeeding the fixed 256-byte, combinational-read, always-enabled store memory. Adds a valid/ready request/response handshake, RISC-V sized loads and stores with sign/zero extension, fault reporting for misaligned, out-of-range and illegal accesses, and a post-reset zero-fill sequence. Sits between the execute/memory stage and the register writeback.

## Interface

- DEPTH_BYTES, 256, memory size in bytes; power of two, ≥ 4.
- ADDR_WIDTH, 32, width of `req_address`; must satisfy 2^ADDR_WIDTH ≥ DEPTH_BYTES.

Ports:

- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on an edge where valid && ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_address  in  ADDR_WIDTH  byte address.
- req_write_data  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed on an edge where valid && ready.
- rsp_read_data  out  32  extended load result; 0 for stores and faults.
- rsp_fault  out  3  [0] misaligned, [1] out of range, [2] illegal size.
- init_done  out  1  zero-fill complete.

## Operation

- States:
  - INIT: counter steps 0..DEPTH_BYTES/4−1 and writes one zero word per cycle. `req_ready` = 0. After the last word is written, the block moves to IDLE and `init_done` rises.
  - IDLE: `req_ready` = 1, `rsp_valid` = 0.
  - RESP: `rsp_valid` = 1. `req_ready` = `rsp_ready`.
- Transitions:
  - IDLE → RESP on accept.
  - RESP → IDLE on response consumed with no new accept.
  - RESP → RESP on simultaneous consume + accept (back-to-back; new response replaces the old one).
- Fault checks are evaluated on the accepting edge:
  - Illegal: `req_size` ∈ {011, 110, 111}; for stores, also {100, 101}.
  - Out of range: `req_address` ≥ DEPTH_BYTES.
  - Misaligned: H/HU with address[0] ≠ 0; W with address[1:0] ≠ 0.
  - Several fault bits may be set together.
- Faulted request: no memory write; `rsp_read_data` = 0.
- Store, applied on the accepting edge:
  - Byte lane offset = address[1:0].
  - SB writes data[7:0] at the offset.
  - SH writes data[15:0] at lane offset 0 or 2.
  - SW writes all four lanes.
- Load:
  - The word at address[A−1:2] (A = log2 DEPTH_BYTES) is read at the accepting edge, then shifted by the offset and extended.
  - B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
  - The result is registered into `rsp_read_data`.
- Response registers (`rsp_read_data`, `rsp_fault`) stay stable while `rsp_valid` && !`rsp_ready`.
- Memory contents are not reset directly; the INIT zero-fill clears them.

## Timing

- Reset values:
  - state = INIT, init counter = 0.
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_read_data` = 0, `rsp_fault` = 0, `init_done` = 0.
- Zero-fill takes DEPTH_BYTES/4 cycles after reset deasserts. `req_ready` first reads 1 in the cycle after the last fill write (64 cycles for the default).
- Latency: request accepted at edge N → `rsp_valid` = 1 after edge N, carrying that request's data.
- Throughput: one request per cycle while `rsp_ready` stays high.
- Read-after-write: a load accepted the cycle after a store to the same word returns the stored data.
- Reset asserted mid-operation, with immediate effect (asynchronous):
  - The pending response is dropped and `rsp_valid` goes to 0.
  - The zero-fill restarts from word 0.
  - Any store not yet clocked is lost.

## Test plan

- Reset, then wait for `init_done`; LW at 0x00 and at 0xFC → `rsp_read_data` = 0x00000000, fault = 000; `req_ready` low for exactly 64 cycles.
- SW 0x80FF7F01 at 0x10; then LB 0x10 → 0x00000001, LB 0x13 → 0xFFFFFF80, LBU 0x13 → 0x00000080, LH 0x12 → 0xFFFF80FF, LHU 0x12 → 0x000080FF.
- SB 0xAA at 0x21, then SH 0xBEEF at 0x22, onto a zeroed word → LW 0x20 = 0xBEEFAA00.
- SW at 0x05 → fault = 001 and LW 0x04 still 0. LW at 0x100 → fault = 010. SB with size 100 → fault = 100. Every faulted response has data 0.
- Hold `rsp_ready` = 0 for 3 cycles after a load → `rsp_valid`, data and fault held stable and `req_ready` = 0. Raise `rsp_ready` with `req_valid` high → back-to-back accept and the second response appears after the next edge.
- SW 0x12345678 at 0x30, issue LW 0x30, assert reset while `rsp_valid` = 1 → `rsp_valid` drops immediately. After the refill, LW 0x30 = 0.

Source files
------------

// File: rtl/data_memory.sv
// data_memory: byte-addressable load/store memory with valid/ready handshake,
// sized/extended accesses, fault reporting and a post-reset zero-fill.
module data_memory #(
  parameter int DEPTH_BYTES = 256,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [31:0]           req_write_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_read_data,
  output logic [2:0]            rsp_fault,
  output logic                  init_done
);
  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int A     = $clog2(DEPTH_BYTES);
  localparam int IW    = (A > 2) ? A - 2 : 1;
  typedef enum logic [1:0] {INIT, IDLE, RESP} state_t;
  state_t state, state_next;
  logic [IW-1:0] cnt, idx;
  logic [31:0] mem [WORDS];
  logic [31:0] sh, load_data, wd;
  logic [3:0] be;
  logic [1:0] off;
  logic [2:0] fault;
  logic accept, oor, illegal, mis, faulty, wr;
  if (A > 2) begin : g_idx
    assign idx = req_address[A-1:2];
  end else begin : g_idx0
    assign idx = '0;
  end
  // Any address bit at or above log2(DEPTH_BYTES) means out of range.
  if (ADDR_WIDTH > A) begin : g_oor
    assign oor = |req_address[ADDR_WIDTH-1:A];
  end else begin : g_oor0
    assign oor = 1'b0;
  end
  assign off       = req_address[1:0];
  assign req_ready = (state == IDLE) || (state == RESP && rsp_ready);
  assign rsp_valid = state == RESP;
  assign init_done = state != INIT;
  assign accept    = req_valid && req_ready;
  always_comb begin
    illegal   = req_size == 3'b011 || (req_size[2] && req_size[1]) || (req_write && req_size[2]);
    mis       = (req_size[1:0] == 2'b01 && off[0]) || (req_size == 3'b010 && |off);
    fault     = {illegal, oor, mis};
    faulty    = |fault;
    wr        = accept && req_write && !faulty;
    be        = req_size[1:0] == 2'b00 ? 4'b0001 << off : req_size[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
    wd        = req_size[1:0] == 2'b00 ? {4{req_write_data[7:0]}} : req_size[1:0] == 2'b01 ? {2{req_write_data[15:0]}} : req_write_data;
    sh        = mem[idx] >> {off, 3'b000};
    load_data = req_size == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
                req_size == 3'b100 ? {24'b0, sh[7:0]} :
                req_size == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
                req_size == 3'b101 ? {16'b0, sh[15:0]} : sh;
    state_next = state == INIT ? (cnt == IW'(WORDS - 1) ? IDLE : INIT) :
                 accept ? RESP : (state == RESP && !rsp_ready) ? RESP : IDLE;
  end
  always_ff @(posedge clock) begin
    if (state == INIT) mem[cnt] <= '0;
    else if (wr)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= INIT;
      cnt           <= '0;
      rsp_read_data <= '0;
      rsp_fault     <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) cnt <= cnt + 1'b1;
      if (accept) begin
        rsp_read_data <= (req_write || faulty) ? 32'b0 : load_data;
        rsp_fault     <= fault;
      end
    end
  end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed stimulus against a byte-array model of data_memory.
module tb_data_memory;
  logic clock = 0, reset = 1;
  logic req_valid = 0, req_ready, req_write = 0, rsp_valid, rsp_ready = 1, init_done;
  logic [2:0] req_size = 0, rsp_fault;
  logic [31:0] req_address = 0, req_write_data = 0, rsp_read_data;
  int checks = 0, errors = 0;
  data_memory dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_address(req_address),
    .req_write_data(req_write_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_read_data(rsp_read_data), .rsp_fault(rsp_fault), .init_done(init_done)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: byte array plus the pending response; fill counts edges since reset.
  logic [7:0] bmem [256];
  int fill = 0;
  logic m_valid = 0;
  logic [31:0] m_data = 0;
  logic [2:0] m_fault = 0;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      fill = 0; m_valid = 0; m_data = 0; m_fault = 0;
      for (int i = 0; i < 256; i++) bmem[i] = 0;
    end else if (fill < 64) fill++;
    else if (req_valid && (!m_valid || rsp_ready)) begin
      int n, a;
      logic [31:0] v;
      a = int'(req_address);
      n = (req_size[1:0] == 0) ? 1 : (req_size[1:0] == 1) ? 2 : 4;
      m_fault[2] = req_size inside {3, 6, 7} || (req_write && req_size inside {4, 5});
      m_fault[1] = req_address >= 256;
      m_fault[0] = ((req_size == 1 || req_size == 5) && a % 2 != 0) || (req_size == 2 && a % 4 != 0);
      v = 0;
      if (m_fault == 0) begin
        for (int i = 0; i < n; i++)
          if (req_write) bmem[a + i] = req_write_data[8*i +: 8];
          else v = v | (32'(bmem[a + i]) << (8 * i));
        if (req_size == 0 && v[7]) v = v | 32'hFFFFFF00;
        if (req_size == 1 && v[15]) v = v | 32'hFFFF0000;
      end
      m_data = (req_write || m_fault != 0) ? 0 : v;
      m_valid = 1;
    end else if (rsp_ready) m_valid = 0;
  end
  always @(negedge clock) begin
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("req_ready", 32'(req_ready), 32'(fill == 64 && (!m_valid || rsp_ready)));
    chk("init_done", 32'(init_done), 32'(fill == 64));
    if (m_valid) begin
      chk("model data", rsp_read_data, m_data);
      chk("model fault", 32'(rsp_fault), 32'(m_fault));
    end
  end
  task automatic req(input logic w, input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    req_valid = 1; req_write = w; req_size = s; req_address = a; req_write_data = d;
    do begin @(negedge clock); n++; end while (!req_ready && n < 100);
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_timeout: ready never rose for addr %08h", a);
    end
    @(posedge clock); #1;
    req_valid = 0;
  endtask
  task automatic expect_rsp(input string name, input logic [31:0] d, input logic [2:0] f);
    @(negedge clock);
    chk({name, " valid"}, 32'(rsp_valid), 1);
    chk({name, " data"}, rsp_read_data, d);
    chk({name, " fault"}, 32'(rsp_fault), 32'(f));
  endtask
  task automatic wait_init(output int cycles);
    cycles = 0;
    while (!req_ready && cycles < 200) begin @(negedge clock); if (!req_ready) cycles++; end
  endtask
  initial begin
    int c;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    c = req_ready ? 0 : 1;
    if (!req_ready) begin wait_init(c); c++; end
    chk("init ready-low cycles", 32'(c), 64);
    @(posedge clock); #1;
    req(0, 3'b010, 32'h00, 0); expect_rsp("LW 0x00", 0, 0);
    req(0, 3'b010, 32'hFC, 0); expect_rsp("LW 0xFC", 0, 0);
    req(1, 3'b010, 32'h10, 32'h80FF7F01);
    req(0, 3'b000, 32'h10, 0); expect_rsp("LB 0x10", 32'h00000001, 0);
    req(0, 3'b000, 32'h13, 0); expect_rsp("LB 0x13", 32'hFFFFFF80, 0);
    req(0, 3'b100, 32'h13, 0); expect_rsp("LBU 0x13", 32'h00000080, 0);
    req(0, 3'b001, 32'h12, 0); expect_rsp("LH 0x12", 32'hFFFF80FF, 0);
    req(0, 3'b101, 32'h12, 0); expect_rsp("LHU 0x12", 32'h000080FF, 0);
    req(1, 3'b000, 32'h21, 32'h000000AA);
    req(1, 3'b001, 32'h22, 32'h0000BEEF);
    req(0, 3'b010, 32'h20, 0); expect_rsp("LW 0x20", 32'hBEEFAA00, 0);
    req(1, 3'b010, 32'h05, 32'hFFFFFFFF); expect_rsp("SW 0x05", 0, 3'b001);
    req(0, 3'b010, 32'h04, 0); expect_rsp("LW 0x04", 0, 0);
    req(0, 3'b010, 32'h100, 0); expect_rsp("LW 0x100", 0, 3'b010);
    req(1, 3'b100, 32'h40, 32'h55); expect_rsp("SB size 100", 0, 3'b100);
    req(0, 3'b011, 32'h103, 0); expect_rsp("multi fault", 0, 3'b110);
    req(0, 3'b001, 32'h11, 0); expect_rsp("LH 0x11", 0, 3'b001);
    req(0, 3'b010, 32'h10, 0);
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("hold valid", 32'(rsp_valid), 1);
      chk("hold data", rsp_read_data, 32'h80FF7F01);
      chk("hold fault", 32'(rsp_fault), 0);
      chk("hold req_ready", 32'(req_ready), 0);
    end
    @(posedge clock); #1;
    rsp_ready = 1;
    req_valid = 1; req_write = 0; req_size = 3'b000; req_address = 32'h13;
    @(negedge clock);
    chk("b2b ready", 32'(req_ready), 1);
    chk("b2b old data", rsp_read_data, 32'h80FF7F01);
    @(posedge clock); #1;
    req_valid = 0;
    expect_rsp("b2b LB 0x13", 32'hFFFFFF80, 0);
    req(1, 3'b010, 32'h30, 32'h12345678);
    req(0, 3'b010, 32'h30, 0);
    rsp_ready = 0;
    #2;
    chk("pre-reset valid", 32'(rsp_valid), 1);
    chk("pre-reset data", rsp_read_data, 32'h12345678);
    reset = 1;
    #1;
    chk("async reset valid", 32'(rsp_valid), 0);
    chk("async reset data", rsp_read_data, 0);
    @(posedge clock); #1;
    reset = 0; rsp_ready = 1;
    wait_init(c);
    chk("refill done", 32'(init_done), 1);
    @(posedge clock); #1;
    req(0, 3'b010, 32'h30, 0); expect_rsp("LW 0x30 after reset", 0, 0);
    repeat (2) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
